// File: rtl/vdp_bus_pkg.sv
// Shared VDP port constants, VRAM write code and loader FSM encoding.
package vdp_bus_pkg;
  localparam logic [7:0] VDP_CTRL_PORT = 8'hBF;
  localparam logic [7:0] VDP_DATA_PORT = 8'hBE;
  localparam logic [1:0] VRAM_WR_CODE  = 2'b01;

  typedef enum logic [2:0] {
    IDLE,
    CTRL_LO,
    CTRL_HI,
    WAIT_SRC,
    DATA_WR,
    FINISH
  } ldr_state_e;
endpackage

// File: rtl/z80_io_cycle.sv
// One Z80 I/O write cycle: T1, T2, TW, T3 of T_CYCLES clocks each, ack pulses after T3.
module z80_io_cycle
  import vdp_bus_pkg::*;
#(
  parameter int unsigned T_CYCLES = 25
)(
  input  logic       clk,
  input  logic       rst_L,
  input  logic       req_i,
  input  logic [7:0] addr_i,
  input  logic [7:0] data_i,
  output logic [7:0] addr_o,
  output logic [7:0] data_o,
  output logic       oe_o,
  output logic       strb_l_o,
  output logic       ack_o
);
  localparam int unsigned   CW    = $clog2(4 * T_CYCLES);
  localparam logic [CW-1:0] T2_AT = CW'(T_CYCLES);
  localparam logic [CW-1:0] T3_AT = CW'(3 * T_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(4 * T_CYCLES - 1);

  logic          act_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    addr_q, data_q;
  logic          oe_q, strb_q, ack_q;

  assign cnt_d = cnt_q + CW'(1);

  // Strobes are registered from the next count so they change exactly on phase boundaries.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      act_q  <= 1'b0;
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      oe_q   <= 1'b0;
      strb_q <= 1'b1;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      if (!act_q) begin
        if (req_i) begin
          act_q  <= 1'b1;
          cnt_q  <= '0;
          addr_q <= addr_i;
          data_q <= data_i;
          oe_q   <= 1'b1;
        end
      end else if (cnt_q == LAST) begin
        act_q  <= 1'b0;
        oe_q   <= 1'b0;
        strb_q <= 1'b1;
        ack_q  <= 1'b1;
      end else begin
        cnt_q  <= cnt_d;
        strb_q <= !((cnt_d >= T2_AT) && (cnt_d < T3_AT));
      end
    end
  end

  assign addr_o   = addr_q;
  assign data_o   = data_q;
  assign oe_o     = oe_q;
  assign strb_l_o = strb_q;
  assign ack_o    = ack_q;
endmodule

// File: rtl/vdp_pattern_loader.sv
// Streams a source byte block into VDP VRAM: two control writes set the address, then data writes.
module vdp_pattern_loader
  import vdp_bus_pkg::*;
#(
  parameter int unsigned T_CYCLES  = 25,
  parameter logic [7:0]  CTRL_PORT = VDP_CTRL_PORT,
  parameter logic [7:0]  DATA_PORT = VDP_DATA_PORT
)(
  input  logic        clk,
  input  logic        rst_L,
  input  logic        start,
  input  logic [13:0] vram_addr,
  input  logic [13:0] byte_count,
  input  logic        src_valid,
  input  logic [7:0]  src_data,
  output logic        src_ready,
  output logic        busy,
  output logic        done,
  output logic [7:0]  addr_bus,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        IORQ_L,
  output logic        WR_L,
  output logic        RD_L
);
  ldr_state_e  state_q;
  logic [5:0]  addr_hi_q;
  logic [13:0] rem_q, rem_d;
  logic        req_q;
  logic [7:0]  req_addr_q, req_data_q;
  logic        src_ready_q, busy_q, done_q;
  logic        io_ack, io_strb_l;

  assign rem_d = rem_q - 14'd1;

  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state_q     <= IDLE;
      addr_hi_q   <= '0;
      rem_q       <= '0;
      req_q       <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      src_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          addr_hi_q  <= vram_addr[13:8];
          rem_q      <= byte_count;
          busy_q     <= 1'b1;
          req_q      <= 1'b1;
          req_addr_q <= CTRL_PORT;
          req_data_q <= vram_addr[7:0];
          state_q    <= CTRL_LO;
        end
        CTRL_LO: if (io_ack) begin
          req_q      <= 1'b1;
          req_addr_q <= CTRL_PORT;
          req_data_q <= {VRAM_WR_CODE, addr_hi_q};
          state_q    <= CTRL_HI;
        end
        CTRL_HI: if (io_ack) begin
          if (rem_q == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else begin
            src_ready_q <= 1'b1;
            state_q     <= WAIT_SRC;
          end
        end
        WAIT_SRC: if (src_valid && src_ready_q) begin
          src_ready_q <= 1'b0;
          req_q       <= 1'b1;
          req_addr_q  <= DATA_PORT;
          req_data_q  <= src_data;
          state_q     <= DATA_WR;
        end
        DATA_WR: if (io_ack) begin
          rem_q <= rem_d;
          if (rem_d == '0) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end else begin
            src_ready_q <= 1'b1;
            state_q     <= WAIT_SRC;
          end
        end
        // done is already high here; a start in this cycle is deliberately dropped.
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  z80_io_cycle #(.T_CYCLES(T_CYCLES)) u_io (
    .clk      (clk),
    .rst_L    (rst_L),
    .req_i    (req_q),
    .addr_i   (req_addr_q),
    .data_i   (req_data_q),
    .addr_o   (addr_bus),
    .data_o   (data_out),
    .oe_o     (data_oe),
    .strb_l_o (io_strb_l),
    .ack_o    (io_ack)
  );

  assign IORQ_L    = io_strb_l;
  assign WR_L      = io_strb_l;
  assign RD_L      = 1'b1;
  assign src_ready = src_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: doc/vdp_pattern_loader.md
VDP_PATTERN_LOADER -- requirements
Module: vdp_pattern_loader

Interface
REQ-001 Parameter T_CYCLES, default 25, clk cycles per Z80 T-state (100 MHz / 4 MHz).
REQ-002 Parameter CTRL_PORT, default 8'hBF, VDP control port address.
REQ-003 Parameter DATA_PORT, default 8'hBE, VDP data port address.
REQ-004 clk  in  1  single clock, all logic on posedge.
REQ-005 rst_L  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request to begin a load; sampled only when busy=0.
REQ-007 vram_addr  in  14  VRAM start address, latched on accepted start.
REQ-008 byte_count  in  14  number of data bytes to send, latched on accepted start.
REQ-009 src_valid  in  1  source byte available.
REQ-010 src_data  in  8  source byte.
REQ-011 src_ready  out  1  loader accepts src_data this cycle.
REQ-012 busy  out  1  high from accepted start until done.
REQ-013 done  out  1  one-cycle pulse at load completion.
REQ-014 addr_bus  out  8  Z80 I/O port address.
REQ-015 data_out  out  8  byte for the shared data bus.
REQ-016 data_oe  out  1  data_out drives data_bus when high.
REQ-017 IORQ_L, WR_L, RD_L  out  1 each  Z80 strobes, active-low.

Function
REQ-018 The block SHALL act as the Z80-side initiator, issuing I/O write cycles only; RD_L SHALL be held 1.
REQ-019 Each write cycle SHALL be 4 phases of T_CYCLES clocks each: T1 (addr_bus, data_out valid, data_oe=1, strobes high), T2 and TW (IORQ_L=WR_L=0), T3 (strobes high, data_oe=1); total 4*T_CYCLES clocks.
REQ-020 addr_bus and data_out SHALL be stable for the whole cycle; between cycles data_oe=0, strobes high.
REQ-021 FSM states SHALL be IDLE, CTRL_LO, CTRL_HI, WAIT_SRC, DATA_WR, FINISH.
REQ-022 IDLE -> CTRL_LO on start; CTRL_LO writes vram_addr[7:0] to CTRL_PORT.
REQ-023 CTRL_HI SHALL write {2'b01, vram_addr[13:8]} (VRAM write code) to CTRL_PORT.
REQ-024 After CTRL_HI: remaining==0 -> FINISH, else -> WAIT_SRC.
REQ-025 WAIT_SRC SHALL assert src_ready; on src_valid&&src_ready capture src_data, go to DATA_WR same edge.
REQ-026 src_ready SHALL be 0 in every state except WAIT_SRC.
REQ-027 DATA_WR SHALL write the captured byte to DATA_PORT, decrement remaining (14-bit), then -> WAIT_SRC if remaining!=0, else FINISH.
REQ-028 FINISH SHALL pulse done for exactly one cycle and return to IDLE; busy falls with done.
REQ-029 src_valid low in WAIT_SRC SHALL stall indefinitely with bus idle.
REQ-030 start while busy=1 SHALL be ignored; start coincident with done SHALL be ignored.
REQ-031 byte_count=0 SHALL issue only the two control writes then done.
REQ-032 The block SHALL not depend on VRAM address wrap; the VDP auto-increments.

Reset
REQ-033 On rst_L=0 at a clock edge: state=IDLE, IORQ_L=WR_L=RD_L=1, data_oe=0, addr_bus=0, data_out=0, src_ready=0, busy=0, done=0, counters=0.
REQ-034 Reset mid-cycle SHALL release strobes on the next edge, with no partial cycle resumed afterwards.

Structure
REQ-035 Package vdp_bus_pkg SHALL hold CTRL_PORT/DATA_PORT defaults, the VRAM-write code 2'b01, and the FSM state enum.
REQ-036 Sub-module z80_io_cycle SHALL generate one write cycle (req/addr/data in, ack pulse at end of T3), instanced once.

Verification
REQ-037 start, vram_addr=14'h0000, byte_count=0 -> writes 8'h00 then 8'h40 to 8'hBF, done 8*T_CYCLES+~2 clocks later.
REQ-038 vram_addr=14'h3A5C, byte_count=3, source 8'h11,8'h22,8'h33 always valid -> port writes BF:5C, BF:7A, BE:11, BE:22, BE:33, one done.
REQ-039 T_CYCLES=25: IORQ_L low exactly 50 clocks per cycle; addr/data stable while data_oe=1.
REQ-040 src_valid held low 500 clocks in WAIT_SRC -> strobes high, data_oe=0, src_ready=1 throughout; resumes on src_valid.
REQ-041 start pulsed mid-load -> ignored, byte count unchanged; rst_L=0 during T2 -> strobes high next edge, busy=0.
